address_sequencer: RTL and testbench



---
 rtl/addrseq_pkg.sv | 21 ++
 rtl/address_sequencer_if.sv | 31 +++
 rtl/addr_stepper.sv | 37 +++
 rtl/address_sequencer.sv | 153 +++++++++++++++
 tb/tb_address_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/addrseq_pkg.sv
//==============================================================================
// Module  : addrseq_pkg
// Brief   : Shared widths and FSM state type for the address sequencer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package addrseq_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_LEN_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/address_sequencer_if.sv
//==============================================================================
// Module  : address_sequencer_if
// Brief   : Valid/ready address stream from the sequencer to the cache.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface address_sequencer_if #(
    parameter int ADDR_W = addrseq_pkg::DEF_ADDR_W
);
    logic              adr_valid;
    logic              adr_ready;
    logic [ADDR_W-1:0] adr;
    logic              adr_last;

    modport master (
        output adr_valid,
        output adr,
        output adr_last,
        input  adr_ready
    );

    modport slave (
        input  adr_valid,
        input  adr,
        input  adr_last,
        output adr_ready
    );
endinterface

`default_nettype wire

// File: rtl/addr_stepper.sv
//==============================================================================
// Module  : addr_stepper
// Brief   : Address register with load and stride-advance (wraps mod 2^ADDR_W).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module addr_stepper #(
    parameter int ADDR_W = addrseq_pkg::DEF_ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              load,
    input  wire logic [ADDR_W-1:0] load_val,
    input  wire logic              advance,
    input  wire logic [ADDR_W-1:0] stride,
    output logic      [ADDR_W-1:0] adr
);

    logic [ADDR_W-1:0] r_adr;

    // Carry out of the top bit is dropped, giving silent modular wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adr <= '0;
        end else if (load) begin
            r_adr <= load_val;
        end else if (advance) begin
            r_adr <= r_adr + stride;
        end
    end

    assign adr = r_adr;

endmodule

`default_nettype wire

// File: rtl/address_sequencer.sv
//==============================================================================
// Module  : address_sequencer
// Brief   : Programmable base/stride/len address stream with start/busy/done.
//           Optional macro ADDRSEQ_REPEAT_EN adds cfg_passes multi-pass replay.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module address_sequencer
    import addrseq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] cfg_base,
    input  wire logic [ADDR_W-1:0] cfg_stride,
    input  wire logic [LEN_W-1:0]  cfg_len,
`ifdef ADDRSEQ_REPEAT_EN
    input  wire logic [3:0]        cfg_passes,
`endif
    address_sequencer_if.master    adr_if,
    output logic                   busy,
    output logic                   done,
    output logic [LEN_W-1:0]       issued_cnt
);

    state_t            r_state;
    state_t            w_next_state;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  r_issued;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] w_adr;
    logic [ADDR_W-1:0] w_load_val;
    logic              w_start_ok;
    logic              w_hs;
    logic              w_pass_end;
    logic              w_final_pass;
    logic              w_last;
    logic              w_load;
    logic              w_advance;

`ifdef ADDRSEQ_REPEAT_EN
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [3:0]        r_passes_left;

    assign w_final_pass = (r_passes_left == 4'd1);
    assign w_load_val   = (r_state == ST_IDLE) ? cfg_base : r_base;
`else
    assign w_final_pass = 1'b1;
    assign w_load_val   = cfg_base;
`endif

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_hs       = (r_state == ST_ISSUE) && adr_if.adr_ready;
    assign w_pass_end = (r_remaining == LEN_W'(1));
    assign w_last     = w_pass_end && w_final_pass;
    // A non-final pass end reloads base in the same cycle, so there is no bubble.
    assign w_load     = (w_start_ok && (cfg_len != '0)) ||
                        (w_hs && w_pass_end && !w_final_pass);
    assign w_advance  = w_hs && !w_pass_end;

    addr_stepper #(
        .ADDR_W (ADDR_W)
    ) u_stepper (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .advance  (w_advance),
        .stride   (r_stride),
        .adr      (w_adr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (cfg_len != '0) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (w_hs && w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        adr_if.adr_valid = (r_state == ST_ISSUE);
        adr_if.adr       = w_adr;
        adr_if.adr_last  = (r_state == ST_ISSUE) && w_last;
        busy             = (r_state != ST_IDLE);
        done             = (r_state == ST_DONE);
        issued_cnt       = r_issued;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_issued    <= '0;
            r_stride    <= '0;
        end else if (w_start_ok) begin
            r_issued    <= '0;
            r_remaining <= cfg_len;
            r_stride    <= cfg_stride;
        end else if (w_hs) begin
            if (r_issued != {LEN_W{1'b1}}) begin
                r_issued <= r_issued + LEN_W'(1);
            end
`ifdef ADDRSEQ_REPEAT_EN
            r_remaining <= (w_pass_end && !w_final_pass) ? r_len
                                                         : r_remaining - LEN_W'(1);
`else
            r_remaining <= r_remaining - LEN_W'(1);
`endif
        end
    end

`ifdef ADDRSEQ_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base        <= '0;
            r_len         <= '0;
            r_passes_left <= 4'd0;
        end else if (w_start_ok) begin
            r_base        <= cfg_base;
            r_len         <= cfg_len;
            r_passes_left <= (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
        end else if (w_hs && w_pass_end && !w_final_pass) begin
            r_passes_left <= r_passes_left - 4'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_address_sequencer.sv
//==============================================================================
// Module  : tb_address_sequencer
// Brief   : Self-checking bench: vector table, hand sequences, random streams.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_address_sequencer;

    localparam int ADDR_W = 15;
    localparam int LEN_W  = 10;
    localparam int AMASK  = 32'h7FFF;
    localparam int CMAX   = 1023;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [ADDR_W-1:0] cfg_stride = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
`ifdef ADDRSEQ_REPEAT_EN
    logic [3:0]        cfg_passes = 4'd0;
`endif
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  issued_cnt;

    int checks   = 0;
    int failures = 0;

    address_sequencer_if #(.ADDR_W(ADDR_W)) adr_if ();

    address_sequencer #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_base   (cfg_base),
        .cfg_stride (cfg_stride),
        .cfg_len    (cfg_len),
`ifdef ADDRSEQ_REPEAT_EN
        .cfg_passes (cfg_passes),
`endif
        .adr_if     (adr_if.master),
        .busy       (busy),
        .done       (done),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int base;
        int stride;
        int len;
        int passes;
        int pct;
        int exp_first;
        int exp_last;
        int exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_passes(input int p);
`ifdef ADDRSEQ_REPEAT_EN
        return (p == 0) ? 1 : p;
`else
        return 1;
`endif
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Expected k-th address: position within the pass times stride, wrapped.
    function automatic int model_adr(input int base, input int stride, input int len, input int k);
        return (base + (k % len) * stride) & AMASK;
    endfunction

    task automatic run_stream(input int base, input int stride, input int len,
                              input int passes, input int pct, input bit noise,
                              output int first, output int last_adr, output int cnt);
        int total;
        int k;
        int cycles;
        int bound;
        bit rdy;
        total    = len * eff_passes(passes);
        k        = 0;
        cycles   = 0;
        bound    = 64 + total * 40;
        first    = -1;
        last_adr = -1;
        @(negedge clk);
        start      = 1'b1;
        cfg_base   = base[ADDR_W-1:0];
        cfg_stride = stride[ADDR_W-1:0];
        cfg_len    = len[LEN_W-1:0];
`ifdef ADDRSEQ_REPEAT_EN
        cfg_passes = passes[3:0];
`endif
        @(negedge clk);
        start = 1'b0;
        while (k < total && cycles < bound) begin
            check("valid", int'(adr_if.adr_valid), 1);
            check("adr", int'(adr_if.adr), model_adr(base, stride, len, k));
            check("last", int'(adr_if.adr_last), int'(k == total - 1));
            check("cnt_run", int'(issued_cnt), sat(k));
            check("busy_run", int'(busy), 1);
            if (k == 0) first = int'(adr_if.adr);
            if (adr_if.adr_last) last_adr = int'(adr_if.adr);
            rdy = ($urandom_range(99) < pct);
            adr_if.adr_ready = rdy;
            if (noise) begin
                start      = $urandom_range(1);
                cfg_base   = ADDR_W'($urandom);
                cfg_stride = ADDR_W'($urandom);
                cfg_len    = LEN_W'($urandom);
            end
            if (rdy) k++;
            @(negedge clk);
            cycles++;
        end
        if (cycles >= bound) check("stream_timeout", k, total);
        start            = 1'b0;
        adr_if.adr_ready = $urandom_range(1);
        check("done_pulse", int'(done), 1);
        check("valid_done", int'(adr_if.adr_valid), 0);
        check("cnt_done", int'(issued_cnt), sat(total));
        cnt = int'(issued_cnt);
        @(negedge clk);
        check("done_clear", int'(done), 0);
        check("busy_idle", int'(busy), 0);
        check("cnt_hold", int'(issued_cnt), sat(total));
    endtask

    initial begin
        int f;
        int l;
        int c;
        int rb;
        int rs;
        int rl;
        int rp;

        vecs.push_back('{32'h0010, 4,      3, 1, 100, 32'h0010, 32'h0018, 3});
        vecs.push_back('{32'h7FFE, 3,      2, 1, 100, 32'h7FFE, 32'h0001, 2});
        vecs.push_back('{32'h1234, 0,      5, 1, 60,  32'h1234, 32'h1234, 5});
        vecs.push_back('{32'h0ABC, 7,      1, 1, 100, 32'h0ABC, 32'h0ABC, 1});
        vecs.push_back('{32'h4000, 32'h7FFF, 4, 1, 50, 32'h4000, 32'h3FFD, 4});
`ifdef ADDRSEQ_REPEAT_EN
        vecs.push_back('{32'h0100, 1,      2, 2, 100, 32'h0100, 32'h0101, 4});
        vecs.push_back('{32'h0200, 2,      3, 0, 70,  32'h0200, 32'h0204, 3});
`endif

        adr_if.adr_ready = 1'b0;
        #12;
        check("rst_valid", int'(adr_if.adr_valid), 0);
        check("rst_adr", int'(adr_if.adr), 0);
        check("rst_last", int'(adr_if.adr_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cnt", int'(issued_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_stream(vecs[i].base, vecs[i].stride, vecs[i].len, vecs[i].passes,
                       vecs[i].pct, 1'b0, f, l, c);
            check("vec_first", f, vecs[i].exp_first);
            check("vec_last", l, vecs[i].exp_last);
            check("vec_cnt", c, vecs[i].exp_cnt);
        end

        // Backpressure holds 0x0014 for two stalled cycles.
        @(negedge clk);
        start = 1'b1; cfg_base = 15'h0010; cfg_stride = 15'd4; cfg_len = 10'd3;
`ifdef ADDRSEQ_REPEAT_EN
        cfg_passes = 4'd1;
`endif
        adr_if.adr_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        check("bp_adr0", int'(adr_if.adr), 32'h0010);
        adr_if.adr_ready = 1'b1;
        @(negedge clk);
        check("bp_adr1", int'(adr_if.adr), 32'h0014);
        adr_if.adr_ready = 1'b0;
        @(negedge clk);
        check("bp_hold1", int'(adr_if.adr), 32'h0014);
        check("bp_cnt1", int'(issued_cnt), 1);
        @(negedge clk);
        check("bp_hold2", int'(adr_if.adr), 32'h0014);
        check("bp_cnt2", int'(issued_cnt), 1);
        check("bp_last0", int'(adr_if.adr_last), 0);
        adr_if.adr_ready = 1'b1;
        @(negedge clk);
        check("bp_adr2", int'(adr_if.adr), 32'h0018);
        check("bp_last", int'(adr_if.adr_last), 1);
        @(negedge clk);
        adr_if.adr_ready = 1'b0;
        check("bp_done", int'(done), 1);
        check("bp_cnt", int'(issued_cnt), 3);
        @(negedge clk);

        // Zero length: no address, done on the next cycle.
        start = 1'b1; cfg_len = 10'd0; adr_if.adr_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        check("z_valid", int'(adr_if.adr_valid), 0);
        check("z_done", int'(done), 1);
        check("z_cnt", int'(issued_cnt), 0);
        @(negedge clk);
        check("z_done_clr", int'(done), 0);
        check("z_valid2", int'(adr_if.adr_valid), 0);

        // Asynchronous reset mid-stream.
        start = 1'b1; cfg_base = 15'h0200; cfg_stride = 15'd2; cfg_len = 10'd10;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("ab_ignore_start", int'(adr_if.adr), 32'h0204);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ab_valid", int'(adr_if.adr_valid), 0);
        check("ab_adr", int'(adr_if.adr), 0);
        check("ab_busy", int'(busy), 0);
        check("ab_cnt", int'(issued_cnt), 0);
        check("ab_last", int'(adr_if.adr_last), 0);
        @(negedge clk);
        check("ab_nodone", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ab_idle", int'(busy), 0);
        run_stream(32'h0300, 5, 4, 1, 100, 1'b0, f, l, c);
        check("ab_restart_cnt", c, 4);

        for (int n = 0; n < 25; n++) begin
            rb = int'($urandom_range(32'h7FFF));
            rs = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(32'h7FFF));
            rl = int'($urandom_range(12));
            rp = int'($urandom_range(3));
            run_stream(rb, rs, rl, rp, int'($urandom_range(100, 30)), 1'b1, f, l, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
